// File: rtl/fir_poly_seq_if.sv
// Sequencer-facing signal bundle for one polyphase decimation chain.
// master = sample/control source, slave = fir_poly_seq.
interface fir_poly_seq_if #(
  parameter int M         = 20,
  parameter int IDX_WIDTH = 16
);
  localparam int AW = $clog2(M);

  logic                 en;
  logic                 din_valid;
  logic                 err_clr;
  logic [AW-1:0]        tap_addr;
  logic                 dsp_acc;
  logic                 dout_valid;
  logic [IDX_WIDTH-1:0] dout_idx;
  logic                 busy;
  logic                 err;

  modport master (
    output en, din_valid, err_clr,
    input  tap_addr, dsp_acc, dout_valid, dout_idx, busy, err
  );

  modport slave (
    input  en, din_valid, err_clr,
    output tap_addr, dsp_acc, dout_valid, dout_idx, busy, err
  );
endinterface

// File: rtl/fir_poly_seq.sv
// Tap-address / DSP-control sequencer for a polyphase decimating FIR sharing one MAC slice.
// state | meaning
// IDLE  | tap_addr parked at 0, waiting for en && din_valid
// PRIME | sweeping, bank delay lines filling, outputs suppressed
// RUN   | sweeping, one dout_valid per sweep at CAPTURE_ADDR+1
module fir_poly_seq #(
  parameter int M            = 20,
  parameter int BANK_LEN     = 6,
  parameter int CAPTURE_ADDR = 8,
  parameter int PRIME_SWEEPS = 6,
  parameter int IDX_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fir_poly_seq_if.slave bus
);
  localparam int AW = $clog2(M);
  localparam int SW = $clog2(PRIME_SWEEPS + 1);
  localparam logic [AW-1:0] TAP_LAST   = AW'(M - 1);
  localparam logic [AW-1:0] TAP_VALID  = AW'(CAPTURE_ADDR + 1);
  localparam logic [SW-1:0] PRIME_LAST = SW'(PRIME_SWEEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        tap_q, tap_d;
  logic [SW-1:0]        sweep_q, sweep_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 err_q, err_d;
  logic                 err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      sweep_q      <= '0;
      idx_q        <= '0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      sweep_q      <= sweep_d;
      idx_q        <= idx_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    sweep_d = sweep_q;
    idx_d   = idx_q + IDX_WIDTH'(dout_valid_q);
    err_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tap_d = '0;
        // The strobe cycle itself is phase 0 of the first sweep.
        if (bus.en && bus.din_valid) begin
          state_d = S_PRIME;
          tap_d   = AW'(1);
          sweep_d = '0;
          idx_d   = '0;
        end
      end
      default: begin
        if (tap_q == '0 && !bus.din_valid) begin
          err_set = 1'b1;
          state_d = S_IDLE;
          tap_d   = '0;
          sweep_d = '0;
        end else begin
          if (tap_q != '0 && bus.din_valid) err_set = 1'b1;
          if (tap_q == TAP_LAST) begin
            tap_d = '0;
            // en low at the wrap wins over any alignment check on the next phase 0.
            if (!bus.en) begin
              state_d = S_IDLE;
              sweep_d = '0;
            end else if (state_q == S_PRIME) begin
              sweep_d = sweep_q + SW'(1);
              if (sweep_q == PRIME_LAST) state_d = S_RUN;
            end
          end else begin
            tap_d = tap_q + AW'(1);
          end
        end
      end
    endcase
    err_d        = err_set | (err_q & ~bus.err_clr);
    dout_valid_d = (state_d == S_RUN) && (tap_d == TAP_VALID);
  end

  assign bus.tap_addr   = tap_q;
  assign bus.dsp_acc    = (tap_q != '0);
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_idx   = idx_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_fir_poly_seq.sv
// Bench for fir_poly_seq: sweep-level reference model feeds an expected-output scoreboard,
// an independent monitor checks every dout_valid pulse for index and timing.
module tb_fir_poly_seq;
  localparam int M            = 20;
  localparam int BANK_LEN     = 6;
  localparam int CAPTURE_ADDR = 8;
  localparam int PRIME_SWEEPS = 6;
  localparam int IDX_WIDTH    = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_poly_seq_if #(.M(M), .IDX_WIDTH(IDX_WIDTH)) bus ();

  fir_poly_seq #(
    .M(M), .BANK_LEN(BANK_LEN), .CAPTURE_ADDR(CAPTURE_ADDR),
    .PRIME_SWEEPS(PRIME_SWEEPS), .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: "active" chain, phase within sweep, sweeps completed since start.
  bit                   m_active;
  int                   m_phase;
  int                   m_sweeps;
  bit                   m_err;
  logic [IDX_WIDTH-1:0] m_idx;

  int exp_idx_q[$];
  int exp_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_phase  = 0;
    m_sweeps = 0;
    m_err    = 1'b0;
    m_idx    = '0;
    exp_idx_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic step(input bit e, input bit d, input bit c);
    bit set;
    @(negedge clk);
    bus.en = e;
    bus.din_valid = d;
    bus.err_clr = c;
    set = 1'b0;
    if (!m_active) begin
      if (e && d) begin
        m_active = 1'b1;
        m_phase  = 1;
        m_sweeps = 0;
        m_idx    = '0;
      end
    end else if (m_phase == 0 && !d) begin
      set      = 1'b1;
      m_active = 1'b0;
      m_sweeps = 0;
    end else begin
      if (m_phase != 0 && d) set = 1'b1;
      if (m_phase == M - 1) begin
        m_phase = 0;
        m_sweeps++;
        if (!e) begin
          m_active = 1'b0;
          m_sweeps = 0;
        end
      end else begin
        m_phase++;
      end
    end
    m_err = set ? 1'b1 : (c ? 1'b0 : m_err);
    if (m_active && m_sweeps >= PRIME_SWEEPS && m_phase == CAPTURE_ADDR + 1) begin
      exp_idx_q.push_back(int'(m_idx));
      exp_cyc_q.push_back(cyc + 1);
      m_idx = m_idx + 1'b1;
    end
    @(posedge clk);
    #1;
    chk("tap_addr", int'(bus.tap_addr), m_phase);
    chk("dsp_acc", int'(bus.dsp_acc), int'(m_phase != 0));
    chk("busy", int'(bus.busy), int'(m_active));
    chk("err", int'(bus.err), int'(m_err));
  endtask

  // Well-behaved source: strobe exactly on phase 0 of each active sweep.
  task automatic aligned(input bit e, input int n);
    for (int i = 0; i < n; i++) step(e, m_active && m_phase == 0, 1'b0);
  endtask

  task automatic advance_to(input int ph);
    int k;
    k = 0;
    while (m_phase != ph && k < 100) begin
      step(1'b1, m_active && m_phase == 0, 1'b0);
      k++;
    end
    chk("advance_to_phase", m_phase, ph);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tap_addr"}, int'(bus.tap_addr), 0);
    chk({tag, "_dsp_acc"}, int'(bus.dsp_acc), 0);
    chk({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
    chk({tag, "_dout_idx"}, int'(bus.dout_idx), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard in index and cycle.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.dout_valid) begin
        tests++;
        if (exp_idx_q.size() == 0) begin
          fails++;
          $display("FAIL dout_valid unexpected at cycle %0d: got 1, expected 0", cyc);
        end else begin
          int ei, ec;
          ei = exp_idx_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (int'(bus.dout_idx) != ei || cyc != ec) begin
            fails++;
            $display("FAIL dout_pulse: got idx %0d at cycle %0d, expected idx %0d at cycle %0d",
                     bus.dout_idx, cyc, ei, ec);
          end
        end
      end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
        tests++;
        fails++;
        $display("FAIL dout_valid missing at cycle %0d: got 0, expected 1 with idx %0d",
                 cyc, exp_idx_q[0]);
        void'(exp_idx_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    bit en_state;
    bit e, d, c;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.din_valid = 1'b0;
    bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with en but no strobe, then start and prime into RUN.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    aligned(1'b1, PRIME_SWEEPS * M + 2 * M);

    // Missing strobe at a sweep boundary.
    advance_to(0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // Re-prime; index restarts at 0.
    step(1'b1, 1'b1, 1'b0);
    aligned(1'b1, PRIME_SWEEPS * M + 15);

    // Spurious strobe mid-sweep in RUN; cadence must not change.
    advance_to(5);
    step(1'b1, 1'b1, 1'b0);
    aligned(1'b1, 2 * M);
    step(1'b1, m_active && m_phase == 0, 1'b1);

    // en dropped at phase 3: sweep finishes, then idle, no error.
    advance_to(3);
    aligned(1'b0, 2 * M);

    // Clear coinciding with a new error: set wins.
    step(1'b1, 1'b1, 1'b0);
    advance_to(4);
    step(1'b1, 1'b1, 1'b1);

    // Async reset mid-sweep.
    advance_to(12);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic: occasional en drops, misaligned/missing strobes, clears.
    en_state = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 4) en_state = 1'b0;
      else if (!en_state && $urandom_range(0, 29) == 0) en_state = 1'b1;
      e = en_state;
      d = m_active ? (m_phase == 0) : ($urandom_range(0, 9) == 0);
      if (m_active && $urandom_range(0, 299) == 0) d = ~d;
      c = ($urandom_range(0, 49) == 0);
      step(e, d, c);
    end
    aligned(1'b1, 2 * M);
    chk("scoreboard_drained", exp_idx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
